// File: rtl/ocp_conv_pkg.sv
// Shared types and helpers for the ROM-weight convolution scheduler.
package ocp_conv_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROM_WAIT = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } sched_state_t;

    // Address width for n locations, never below one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must reach n itself.
    function automatic int unsigned count_width(input int unsigned n);
        return width_of(n + 1);
    endfunction

endpackage

// File: rtl/ocp_sched_skid.sv
// Two-entry skid buffer between the feature memory and the engine pixel port.
// Tracks the single outstanding read so issue never overruns the storage.
module ocp_sched_skid
    import ocp_conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  out_ready,
    output logic                  out_valid_c,
    output logic [DATA_WIDTH-1:0] out_data_c,
    output logic                  can_issue_c,
    output logic                  empty_c
);

    localparam int unsigned PTR_W = width_of(SKID_DEPTH);
    localparam int unsigned CNT_W = count_width(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] entry [SKID_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  in_flight;
    logic                  pop;
    logic                  pop_stored;
    logic                  push;

    // Returning data bypasses storage when the buffer is empty.
    assign out_valid_c = (count != '0) || in_flight;
    assign out_data_c  = (count != '0) ? entry[rd_ptr]
                       : (in_flight ? rd_data : '0);
    assign pop         = out_valid_c && out_ready;
    assign pop_stored  = pop && (count != '0);
    assign push        = in_flight && !(pop && (count == '0));
    assign can_issue_c = (count + CNT_W'(in_flight)) < CNT_W'(SKID_DEPTH);
    assign empty_c     = (count == '0) && !in_flight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= rd_issue;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_stored)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop_stored)
                count <= count + CNT_W'(1);
            else if (!push && pop_stored)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            entry[wr_ptr] <= rd_data;
    end

endmodule

// File: rtl/ocp_conv_scheduler.sv
// Channel sequencer for the ROM-weight 3x3 convolution engine.
// Optional perf counters are built when OCP_SCHED_PERF_EN is defined.
module ocp_conv_scheduler
    import ocp_conv_pkg::*;
#(
    parameter int unsigned IN_CHANNELS = 256,
    parameter int unsigned IMG_WIDTH   = 32,
    parameter int unsigned IMG_HEIGHT  = 32,
    parameter int unsigned OUT_PIX     = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2),
    parameter int unsigned DATA_WIDTH  = 8,
    localparam int unsigned FRAME      = IMG_WIDTH * IMG_HEIGHT,
    localparam int unsigned CH_W       = width_of(IN_CHANNELS),
    localparam int unsigned PIX_W      = width_of(FRAME),
    localparam int unsigned FM_AW      = width_of(IN_CHANNELS * FRAME)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fm_rd_en,
    output logic [FM_AW-1:0]      fm_rd_addr,
    input  logic [DATA_WIDTH-1:0] fm_rd_data,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  din_valid,
    input  logic                  din_ready,
    output logic [CH_W-1:0]       rom_addr,
    input  logic                  dout_valid,
    output logic [PIX_W-1:0]      psum_rd_addr,
    output logic                  psum_zero,
    output logic                  psum_wr_en,
    output logic [PIX_W-1:0]      psum_wr_addr,
    output logic                  last_ch
`ifdef OCP_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls
`endif
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(IN_CHANNELS - 1);

    sched_state_t      state, state_nxt;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic [PIX_W-1:0]  pix, pix_nxt;
    logic [PIX_W-1:0]  out_cnt, cnt_nxt;
    logic [FM_AW-1:0]  fm_addr, addr_nxt;
    logic              can_issue;
    logic              skid_empty;
    logic              chan_done;

    ocp_sched_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .rd_issue    (fm_rd_en),
        .rd_data     (fm_rd_data),
        .out_ready   (din_ready),
        .out_valid_c (din_valid),
        .out_data_c  (din),
        .can_issue_c (can_issue),
        .empty_c     (skid_empty)
    );

    assign fm_rd_en     = (state == STREAM) && can_issue;
    assign fm_rd_addr   = fm_addr;
    assign rom_addr     = ch;
    assign psum_wr_en   = dout_valid && ((state == STREAM) || (state == DRAIN))
                        && (out_cnt < PIX_W'(OUT_PIX));
    assign psum_wr_addr = out_cnt;
    assign psum_rd_addr = out_cnt;

    // Channel ends once the final write lands and nothing is left to deliver.
    assign chan_done = skid_empty
                     && ((out_cnt == PIX_W'(OUT_PIX))
                         || (psum_wr_en && (out_cnt == PIX_W'(OUT_PIX - 1))));

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        pix_nxt   = pix;
        cnt_nxt   = out_cnt;
        addr_nxt  = fm_addr;
        if (fm_rd_en) begin
            pix_nxt  = pix + PIX_W'(1);
            addr_nxt = fm_addr + FM_AW'(1);
        end
        if (psum_wr_en)
            cnt_nxt = out_cnt + PIX_W'(1);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ROM_WAIT;
                    ch_nxt    = '0;
                    pix_nxt   = '0;
                    cnt_nxt   = '0;
                    addr_nxt  = '0;
                end
            end
            ROM_WAIT: state_nxt = STREAM;
            STREAM: begin
                if (fm_rd_en && (pix == PIX_W'(FRAME - 1)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (chan_done) begin
                    if (ch == LAST_CH) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ROM_WAIT;
                        ch_nxt    = ch + CH_W'(1);
                        pix_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags are registered from the next-state view so they align with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            pix       <= '0;
            out_cnt   <= '0;
            fm_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            psum_zero <= 1'b0;
            last_ch   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            pix       <= pix_nxt;
            out_cnt   <= cnt_nxt;
            fm_addr   <= addr_nxt;
            busy      <= state_nxt inside {ROM_WAIT, STREAM, DRAIN};
            done      <= (state_nxt == DONE);
            psum_zero <= (state_nxt != IDLE) && (ch_nxt == '0);
            last_ch   <= (state_nxt != IDLE) && (ch_nxt == LAST_CH);
        end
    end

`ifdef OCP_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if ((state == IDLE) && start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && (perf_cycles != '1))
                perf_cycles <= perf_cycles + 32'd1;
            if (din_valid && !din_ready && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ocp_conv_scheduler.sv
// Bench for ocp_conv_scheduler: 2 channels of 4x4 against a memory/engine reference model.
module tb_ocp_conv_scheduler;

    localparam int unsigned IN_CH   = 2;
    localparam int unsigned IMG_W   = 4;
    localparam int unsigned IMG_H   = 4;
    localparam int unsigned OUT_PIX = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned FRAME   = IMG_W * IMG_H;
    localparam int unsigned NW      = IN_CH * FRAME;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          fm_rd_en;
    logic [4:0]    fm_rd_addr;
    logic [DW-1:0] fm_rd_data;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [0:0]    rom_addr;
    logic          dout_valid;
    logic [3:0]    psum_rd_addr;
    logic          psum_zero;
    logic          psum_wr_en;
    logic [3:0]    psum_wr_addr;
    logic          last_ch;
`ifdef OCP_SCHED_PERF_EN
    logic [31:0]   perf_cycles;
    logic [31:0]   perf_stalls;
`endif

    ocp_conv_scheduler #(
        .IN_CHANNELS (IN_CH),
        .IMG_WIDTH   (IMG_W),
        .IMG_HEIGHT  (IMG_H),
        .OUT_PIX     (OUT_PIX),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .fm_rd_en     (fm_rd_en),
        .fm_rd_addr   (fm_rd_addr),
        .fm_rd_data   (fm_rd_data),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .rom_addr     (rom_addr),
        .dout_valid   (dout_valid),
        .psum_rd_addr (psum_rd_addr),
        .psum_zero    (psum_zero),
        .psum_wr_en   (psum_wr_en),
        .psum_wr_addr (psum_wr_addr),
        .last_ch      (last_ch)
`ifdef OCP_SCHED_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_stalls  (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [NW];
    int  n_checks, n_pass, cyc;
    int  exp_rd, exp_pix, done_cnt, last_wr_cyc, last_acc_cyc, busy_cycles, stall_left;
    int  eng_cnt [IN_CH];
    int  eng_ch, rd_pend_addr;
    int  start_cyc, first_busy, first_rd, first_dv;
    bit  rand_ready, extra_mode, rd_pend, eng_pend, prev_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({busy, done, fm_rd_en, din_valid, psum_wr_en, psum_zero, last_ch,
                    fm_rd_addr, rom_addr, psum_rd_addr, psum_wr_addr, din});
    endfunction

    // Check everything visible this cycle and advance the reference model.
    task automatic observe();
        int local_pix;
        int exp_done;
        if (dout_valid && eng_cnt[eng_ch] < int'(OUT_PIX)) begin
            check("wr_en", 64'(psum_wr_en), 64'(1));
            check("wr_addr", 64'(psum_wr_addr), 64'(eng_cnt[eng_ch]));
            check("psum_rd_addr", 64'(psum_rd_addr), 64'(eng_cnt[eng_ch]));
            check("psum_zero", 64'(psum_zero), 64'(eng_ch == 0));
            check("last_ch", 64'(last_ch), 64'(eng_ch == int'(IN_CH) - 1));
            eng_cnt[eng_ch]++;
            if (eng_ch == int'(IN_CH) - 1 && eng_cnt[eng_ch] == int'(OUT_PIX))
                last_wr_cyc = cyc;
        end else begin
            check(dout_valid ? "wr_extra_dropped" : "wr_quiet", 64'(psum_wr_en), 64'(0));
        end

        if (fm_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            check("fm_rd_addr", 64'(fm_rd_addr), 64'(exp_rd));
            check("rom_at_read", 64'(rom_addr), 64'(exp_rd / int'(FRAME)));
            exp_rd++;
        end
        rd_pend      = fm_rd_en;
        rd_pend_addr = int'(fm_rd_addr);

        if (din_valid && first_dv < 0) first_dv = cyc;
        eng_pend = 1'b0;
        if (din_valid && din_ready) begin
            if (exp_pix >= int'(NW)) begin
                check("pixel_beyond_map", 64'(exp_pix), 64'(NW - 1));
            end else begin
                check("din", 64'(din), 64'(mem[exp_pix]));
                check("rom_hold", 64'(rom_addr), 64'(exp_pix / int'(FRAME)));
                local_pix = exp_pix % int'(FRAME);
                eng_pend  = local_pix >= int'(FRAME - OUT_PIX) - (extra_mode ? 1 : 0);
                eng_ch    = exp_pix / int'(FRAME);
                exp_pix++;
                if (exp_pix == int'(NW)) last_acc_cyc = cyc;
            end
        end
        if (fm_rd_en)
            check("outstanding_le2", 64'((exp_rd - exp_pix) <= 2), 64'(1));

        if (busy) begin
            busy_cycles++;
            if (first_busy < 0) first_busy = cyc;
        end
        if (done) begin
            done_cnt++;
            exp_done = ((last_wr_cyc > last_acc_cyc + 1) ? last_wr_cyc : last_acc_cyc + 1) + 1;
            check("done_timing", 64'(cyc), 64'(exp_done));
            check("busy_at_done", 64'(busy), 64'(0));
            check("busy_before_done", 64'(prev_busy), 64'(1));
        end
        prev_busy = busy;
    endtask

    task automatic step(input bit st);
        @(negedge clk);
        cyc++;
        start = st;
        if (stall_left > 0 && din_valid) begin
            din_ready = 1'b0;
            stall_left--;
        end else begin
            din_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        fm_rd_data = rd_pend ? mem[rd_pend_addr] : DW'($urandom);
        dout_valid = eng_pend;
        #1;
        observe();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst        = 1'b1;
        start      = 1'b0;
        dout_valid = 1'b0;
        #1;
        check("rst_mid_outputs", all_outputs(), 64'(0));
        @(negedge clk);
        rst      = 1'b0;
        rd_pend  = 1'b0;
        eng_pend = 1'b0;
    endtask

    task automatic run_pass(input bit rr, input bit ex, input bit spam, input bit abort,
                            input int stalls);
        for (int i = 0; i < int'(NW); i++) mem[i] = DW'($urandom);
        for (int c = 0; c < int'(IN_CH); c++) eng_cnt[c] = 0;
        exp_rd = 0; exp_pix = 0; done_cnt = 0; busy_cycles = 0;
        last_wr_cyc = -10; last_acc_cyc = -10;
        first_busy = -1; first_rd = -1; first_dv = -1;
        rand_ready = rr; extra_mode = ex; stall_left = stalls;
        rd_pend = 1'b0; eng_pend = 1'b0;

        step(1'b1);
        start_cyc = cyc;
        check("busy_on_start_cycle", 64'(busy), 64'(0));
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            step(spam && busy && ($urandom_range(0, 3) == 0));
            if (abort && exp_rd >= int'(FRAME) + 3) begin
                mid_reset();
                return;
            end
        end
        check("done_seen", 64'(done_cnt), 64'(1));
        repeat (4) step(1'b0);
        check("done_once", 64'(done_cnt), 64'(1));
        check("pixels_delivered", 64'(exp_pix), 64'(NW));
        check("reads_issued", 64'(exp_rd), 64'(NW));
        check("writes_ch0", 64'(eng_cnt[0]), 64'(OUT_PIX));
        check("writes_ch1", 64'(eng_cnt[1]), 64'(OUT_PIX));
        check("t_busy", 64'(first_busy - start_cyc), 64'(1));
        check("t_first_rd", 64'(first_rd - start_cyc), 64'(2));
        check("t_first_dv", 64'(first_dv - start_cyc), 64'(3));
        check("idle_after", 64'(busy), 64'(0));
`ifdef OCP_SCHED_PERF_EN
        check("perf_cycles", 64'(perf_cycles), 64'(busy_cycles));
        if (stalls > 0)
            check("perf_stalls", 64'(perf_stalls), 64'(stalls));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "bench watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; din_ready = 1'b0; dout_valid = 1'b1; fm_rd_data = '0;
        rd_pend = 1'b0; eng_pend = 1'b0; prev_busy = 1'b0; eng_ch = 0;
        stall_left = 0; rand_ready = 1'b0; extra_mode = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", all_outputs(), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_dout_ignored", 64'(psum_wr_en), 64'(0));
        @(negedge clk);
        dout_valid = 1'b0;

        run_pass(1'b0, 1'b0, 1'b0, 1'b0, 0);   // ready high, nominal
        run_pass(1'b1, 1'b0, 1'b1, 1'b0, 0);   // random ready, start spam while busy
        run_pass(1'b1, 1'b0, 1'b0, 1'b1, 0);   // reset during channel 1 stream
        run_pass(1'b1, 1'b0, 1'b0, 1'b0, 0);   // full pass after the abort
        run_pass(1'b1, 1'b1, 1'b0, 1'b0, 0);   // engine emits one extra result
        run_pass(1'b0, 1'b0, 1'b0, 1'b0, 10);  // ten forced stall cycles

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ocp_conv_scheduler.md
# ocp_conv_scheduler

Sequencing controller for the ROM-weight 3x3 convolution engine. For each input channel in turn it selects the weight ROM row, streams one full feature map from the feature memory into the engine's pixel port, and steers the partial-sum buffer read/write addresses so the engine accumulates across channels. After the last channel, the partial-sum buffer holds final results. The block sits between the layer-level control (start/done) and one engine instance.

## Interface
- IN_CHANNELS, 256, input channels per pass; also the number of ROM rows
- IMG_WIDTH, 32, feature-map width
- IMG_HEIGHT, 32, feature-map height
- OUT_PIX, (IMG_WIDTH-2)*(IMG_HEIGHT-2), engine output pixels expected per channel
- DATA_WIDTH, 8, pixel width
- Derived: CH_W=$clog2(IN_CHANNELS), PIX_W=$clog2(IMG_WIDTH*IMG_HEIGHT), FM_AW=$clog2(IN_CHANNELS*IMG_WIDTH*IMG_HEIGHT)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; starts a pass when idle, ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the last psum write of the last channel has completed
- fm_rd_en  out  1  feature-memory read strobe; data returns exactly one cycle later
- fm_rd_addr  out  FM_AW  ch*IMG_WIDTH*IMG_HEIGHT + pix
- fm_rd_data  in  DATA_WIDTH  read data
- din  out  DATA_WIDTH  pixel to the engine
- din_valid  out  1  pixel valid
- din_ready  in  1  engine accept
- rom_addr  out  CH_W  current channel; held stable for the whole channel
- dout_valid  in  1  engine result valid
- psum_rd_addr  out  PIX_W  current output index; the psum buffer is async-read
- psum_zero  out  1  high while ch==0; the external mux then feeds zero as psum_in
- psum_wr_en  out  1  equals dout_valid, gated by STREAM/DRAIN
- psum_wr_addr  out  PIX_W  equals psum_rd_addr
- last_ch  out  1  high while ch==IN_CHANNELS-1 (writes are final results)

## Operation
- States: IDLE, ROM_WAIT, STREAM, DRAIN, DONE.
- IDLE: on start, clear ch, pix and out_cnt; go to ROM_WAIT.
- ROM_WAIT: one cycle for the synchronous ROM to present the row for rom_addr; then go to STREAM.
- STREAM: issue reads in address order. Once pix reaches IMG_WIDTH*IMG_HEIGHT, go to DRAIN.
- DRAIN: wait until out_cnt==OUT_PIX and the skid buffer is empty.
  - If ch==IN_CHANNELS-1, go to DONE.
  - Otherwise ch++, clear pix and out_cnt, go to ROM_WAIT.
- DONE: pulse done for one cycle; return to IDLE.
- Skid buffer: 2 entries. fm_rd_en is asserted only when (occupancy + reads in flight) < 2, so no data is ever dropped.
  - din and din_valid come from the head entry.
  - The head pops on din_valid && din_ready.
  - A push and a pop in the same cycle keep occupancy unchanged.
- Output counting: on every dout_valid in STREAM/DRAIN, assert psum_wr_en at out_cnt, then out_cnt++.
- dout_valid in IDLE, ROM_WAIT or DONE is ignored and counted nowhere.
- out_cnt must not exceed OUT_PIX. An extra dout_valid is dropped (no write).
- Reset mid-pass: all state clears immediately. psum buffer contents are undefined and the pass must be restarted.

## Timing
- Reset values: busy, done, fm_rd_en, din_valid, psum_wr_en and psum_zero are 0; all addresses are 0; din is 0; last_ch is 0.
- start at cycle T: busy=1 at T+1; ROM_WAIT at T+1; first fm_rd_en at T+2; first din_valid at T+3.
- With din_ready held high, one pixel per cycle; channel time is IMG_WIDTH*IMG_HEIGHT + 1 cycles plus the engine drain.
- psum_wr_en/psum_wr_addr are combinational from dout_valid and the out_cnt register (same cycle as engine dout).
- done is asserted the cycle after the final write; busy falls together with done.

## Configuration
- OCP_SCHED_PERF_EN:
  - Defined: adds 32-bit outputs perf_cycles (cycles while busy) and perf_stalls (cycles with din_valid && !din_ready). Both clear on accepted start and saturate at all-ones.
  - Undefined: the ports and counters are absent.

## Structure
- Shared package ocp_conv_pkg holds:
  - the state enum (IDLE=0, ROM_WAIT=1, STREAM=2, DRAIN=3, DONE=4);
  - width helper functions;
  - the SKID_DEPTH=2 constant.
- One sub-module: ocp_sched_skid, the 2-entry valid/ready buffer with in-flight credit counting.

## Test plan
- IN_CHANNELS=2, 4x4 image, OUT_PIX=4, din_ready=1, engine model emits 4 results -> fm_rd_addr runs 0..31; rom_addr=0 then 1; psum_zero high for ch0 only; 8 writes at addresses 0..3,0..3; done once.
- Random din_ready (50%) -> din sequence identical to the memory contents; no pixel lost or duplicated; fm_rd_en never creates more than 2 outstanding entries.
- start pulsed while busy -> ignored; only one done.
- rst asserted during STREAM of ch1 -> all outputs are 0 next edge; a new start gives a full, correct pass.
- Engine emits a 5th dout_valid with OUT_PIX=4 -> no 5th write; the scheduler still advances correctly.
- OCP_SCHED_PERF_EN defined, din_ready low for 10 stall cycles -> perf_stalls=10; perf_cycles equals the busy cycle count.
